pipeline_trace_buffer: RTL and testbench
========================================

Name: pipeline_trace_buffer

Overview:
Hardware retire-trace capture for the 5-stage RV32I pipeline. It records write-back events (PC, rd, write data) into a parametrised circular buffer, stops on a PC-match or forced trigger after a programmable post-trigger count, then plays the entries back oldest-first. It sits beside the core on the WB-stage signals and replaces waveform-only probing with an on-chip pre/post-trigger history.

Parameters:
DEPTH, 16, number of trace entries; power of 2, at least 2
PC_WIDTH, 32, width of captured PC and trigger PC
DATA_WIDTH, 32, width of captured write-back data
CNT_W, $clog2(DEPTH)+1, width of count and post_count
ENTRY_W, PC_WIDTH+5+DATA_WIDTH, packed entry width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse; clear the buffer and start capture
trig_en  in  1  enable the PC-match trigger
trig_pc  in  PC_WIDTH  trigger PC compare value
force_trig  in  1  pulse; trigger without a PC match
post_count  in  CNT_W  entries to store after the trigger entry
cap_valid  in  1  retire event valid (WB stage)
cap_pc  in  PC_WIDTH  retiring PC
cap_waddr  in  5  destination register
cap_data  in  DATA_WIDTH  write-back data
rd_req  in  1  request next trace entry
rd_entry  out  ENTRY_W  {pc, waddr, data} of the read entry
rd_valid  out  1  rd_entry valid this cycle
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
count  out  CNT_W  stored entries, saturates at DEPTH
triggered  out  1  trigger has occurred since the last arm

Behaviour:
- Reset (async, rstn=0): state=IDLE; wr_ptr, rd_ptr, count, post_remaining and rd_remaining = 0; rd_entry=0; rd_valid=0; triggered=0. Storage array is not reset. Reset asserted in any state aborts immediately.
- arm (any state): next state ARMED; wr_ptr, count and triggered cleared. No capture occurs in the arm cycle. arm has priority over every other input.
- IDLE: cap_valid, force_trig and rd_req are ignored.
- ARMED: on each cap_valid=1, mem[wr_ptr]<=entry; wr_ptr<=wr_ptr+1 mod DEPTH; count<=min(count+1,DEPTH). Cycles with cap_valid=0 store nothing.
- Trigger conditions (ARMED only):
  - PC match: cap_valid & trig_en & (cap_pc==trig_pc). The matching entry is stored.
  - force_trig=1: no entry is stored unless cap_valid is also high in that cycle.
  - Both conditions in the same cycle count as one trigger.
- On trigger: triggered<=1; post_remaining<=min(post_count, DEPTH-1), sampled in that cycle. The clamp guarantees the trigger entry is never overwritten.
  - If the clamped value is 0, next state is DONE; otherwise next state is POST.
- POST: capture as in ARMED. Each stored entry decrements post_remaining; the store that brings it to 0 moves the state to DONE in the next cycle. Further triggers are ignored.
- Entering DONE: rd_ptr<=(count==DEPTH) ? wr_ptr : 0, i.e. the oldest entry; rd_remaining<=count. Capture stops.
- DONE read, 1-cycle latency:
  - rd_req with rd_remaining>0: next cycle rd_entry=mem[rd_ptr] and rd_valid=1; rd_ptr increments mod DEPTH; rd_remaining decrements.
  - rd_req with rd_remaining=0, or any rd_req outside DONE: rd_valid=0 next cycle and rd_entry holds its value.
  - rd_valid is 0 in every cycle without a serviced request.
- count stays constant through DONE; arm clears it.

Test Plan:
- DEPTH=16, arm, trig_en=1, trig_pc=0x08, post_count=2; cap PCs 0x00,0x04,0x08,0x0C,0x10 -> state DONE after the 0x10 capture, count=5, triggered=1. Reads return PCs 0x00..0x10 in order; the 6th rd_req gives rd_valid=0.
- Wrap: trig_pc=0x50, post_count=3; cap PCs 4*i for i=0..23 -> count=16; 16 reads return PCs 0x20 through 0x5C ascending.
- post_count=0, trig_pc=0x0C -> DONE in the cycle after the 0x0C capture, and that entry is the last one read.
- trig_en=0, force_trig with cap_valid=0, post_count=4 -> state POST; 4 captures then DONE, count=4. A later force_trig in DONE has no effect.
- Gapped capture: cap_valid toggling 1,0,1 with cap_waddr=5, cap_data=0xDEADBEEF -> count=2; rd_entry={pc,5'd5,32'hDEADBEEF}; clamp check with post_count=31 on DEPTH=16 stores at most 16 entries with the trigger entry oldest.
- rstn low mid-POST -> state=IDLE, count=0, triggered=0, rd_valid=0 without a clock edge; subsequent cap_valid is ignored until arm.

Source files
------------

// File: rtl/pipeline_trace_buffer.sv
// Retire-trace capture: circular buffer of WB events with PC/forced trigger,
// post-trigger fill, then oldest-first playback.
//
// Ports:
//   clk, rstn          clock (rising edge), async active-low reset
//   arm                pulse: clear buffer and start capture
//   trig_en, trig_pc   PC-match trigger enable and compare value
//   force_trig         pulse: trigger without a PC match
//   post_count         entries to store after the trigger entry
//   cap_valid/pc/waddr/data   WB retire event
//   rd_req             request next trace entry (DONE only)
//   rd_entry, rd_valid {pc, waddr, data} of the read entry, 1-cycle latency
//   state, count, triggered   status
module pipeline_trace_buffer #(
   parameter int DEPTH      = 16,
   parameter int PC_WIDTH   = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = $clog2(DEPTH) + 1,
   parameter int ENTRY_W    = PC_WIDTH + 5 + DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  arm,
   input  logic                  trig_en,
   input  logic [PC_WIDTH-1:0]   trig_pc,
   input  logic                  force_trig,
   input  logic [CNT_W-1:0]      post_count,
   input  logic                  cap_valid,
   input  logic [PC_WIDTH-1:0]   cap_pc,
   input  logic [4:0]            cap_waddr,
   input  logic [DATA_WIDTH-1:0] cap_data,
   input  logic                  rd_req,
   output logic [ENTRY_W-1:0]    rd_entry,
   output logic                  rd_valid,
   output logic [1:0]            state,
   output logic [CNT_W-1:0]      count,
   output logic                  triggered
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   // Clamp keeps the trigger entry from being overwritten by post fill.
   localparam logic [CNT_W-1:0] MAX_POST = CNT_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   post_rem_q, post_rem_d;
   logic [CNT_W-1:0]   rd_rem_q, rd_rem_d;
   logic [ENTRY_W-1:0] rd_entry_q, rd_entry_d;
   logic               rd_valid_q, rd_valid_d;
   logic               triggered_q, triggered_d;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] cap_entry;
   logic               wr_en;
   logic               trig_hit;
   logic [CNT_W-1:0]   post_clamp;

   assign cap_entry  = {cap_pc, cap_waddr, cap_data};
   assign post_clamp = (post_count > MAX_POST) ? MAX_POST : post_count;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      post_rem_d  = post_rem_q;
      rd_rem_d    = rd_rem_q;
      rd_entry_d  = rd_entry_q;
      rd_valid_d  = 1'b0;
      triggered_d = triggered_q;
      wr_en       = 1'b0;
      trig_hit    = 1'b0;

      if (arm) begin
         state_d     = ST_ARMED;
         wr_ptr_d    = '0;
         count_d     = '0;
         triggered_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
            end
            ST_ARMED: begin
               if (cap_valid) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (count_q != DEPTH_C)
                     count_d = count_q + 1'b1;
               end
               trig_hit = (cap_valid & trig_en & (cap_pc == trig_pc))
                        | force_trig;
               if (trig_hit) begin
                  triggered_d = 1'b1;
                  post_rem_d  = post_clamp;
                  state_d     = (post_clamp == '0) ? ST_DONE : ST_POST;
               end
            end
            ST_POST: begin
               if (cap_valid) begin
                  wr_en      = 1'b1;
                  wr_ptr_d   = wr_ptr_q + 1'b1;
                  post_rem_d = post_rem_q - 1'b1;
                  if (count_q != DEPTH_C)
                     count_d = count_q + 1'b1;
                  if (post_rem_q == CNT_W'(1))
                     state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (rd_req && rd_rem_q != '0) begin
                  rd_entry_d = mem[rd_ptr_q];
                  rd_valid_d = 1'b1;
                  rd_ptr_d   = rd_ptr_q + 1'b1;
                  rd_rem_d   = rd_rem_q - 1'b1;
               end
            end
         endcase

         // Playback starts at the oldest entry, seen after this cycle's store.
         if (state_d == ST_DONE && state_q != ST_DONE) begin
            rd_ptr_d = (count_d == DEPTH_C) ? wr_ptr_d : '0;
            rd_rem_d = count_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         post_rem_q  <= '0;
         rd_rem_q    <= '0;
         rd_entry_q  <= '0;
         rd_valid_q  <= 1'b0;
         triggered_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         post_rem_q  <= post_rem_d;
         rd_rem_q    <= rd_rem_d;
         rd_entry_q  <= rd_entry_d;
         rd_valid_q  <= rd_valid_d;
         triggered_q <= triggered_d;
      end
   end

   // Trace storage carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_q] <= cap_entry;
   end

   assign rd_entry  = rd_entry_q;
   assign rd_valid  = rd_valid_q;
   assign state     = state_q;
   assign count     = count_q;
   assign triggered = triggered_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench for pipeline_trace_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the trace buffer.
module tb_pipeline_trace_buffer;

   localparam int DEPTH   = 16;
   localparam int PW      = 32;
   localparam int DW      = 32;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = PW + 5 + DW;

   logic               clk = 1'b0;
   logic               rstn;
   logic               arm;
   logic               trig_en;
   logic [PW-1:0]      trig_pc;
   logic               force_trig;
   logic [CNT_W-1:0]   post_count;
   logic               cap_valid;
   logic [PW-1:0]      cap_pc;
   logic [4:0]         cap_waddr;
   logic [DW-1:0]      cap_data;
   logic               rd_req;
   logic [ENTRY_W-1:0] dut_entry;
   logic               dut_valid;
   logic [1:0]         dut_state;
   logic [CNT_W-1:0]   dut_count;
   logic               dut_trig;

   int n_tests = 0;
   int n_fail  = 0;

   pipeline_trace_buffer #(
      .DEPTH(DEPTH), .PC_WIDTH(PW), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rstn(rstn), .arm(arm),
      .trig_en(trig_en), .trig_pc(trig_pc),
      .force_trig(force_trig), .post_count(post_count),
      .cap_valid(cap_valid), .cap_pc(cap_pc),
      .cap_waddr(cap_waddr), .cap_data(cap_data),
      .rd_req(rd_req), .rd_entry(dut_entry), .rd_valid(dut_valid),
      .state(dut_state), .count(dut_count), .triggered(dut_trig)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   typedef logic [ENTRY_W-1:0] entry_t;
   entry_t m_q[$];
   entry_t m_rdq[$];
   int     m_state;
   int     m_post;
   bit     m_trig;
   entry_t m_rd_entry;
   bit     m_rd_valid;

   task automatic model_reset();
      m_q.delete();
      m_rdq.delete();
      m_state    = 0;
      m_post     = 0;
      m_trig     = 0;
      m_rd_entry = '0;
      m_rd_valid = 0;
   endtask

   task automatic model_update();
      int pc_lim;
      m_rd_valid = 0;
      if (arm) begin
         m_state = 1;
         m_q.delete();
         m_trig = 0;
      end else if (m_state == 1 || m_state == 2) begin
         if (cap_valid) begin
            if (m_q.size() == DEPTH) void'(m_q.pop_front());
            m_q.push_back({cap_pc, cap_waddr, cap_data});
         end
         if (m_state == 1) begin
            if ((cap_valid && trig_en && cap_pc == trig_pc) || force_trig) begin
               m_trig = 1;
               pc_lim = int'(post_count);
               m_post = (pc_lim > DEPTH - 1) ? DEPTH - 1 : pc_lim;
               if (m_post == 0) begin
                  m_state = 3;
                  m_rdq = m_q;
               end else m_state = 2;
            end
         end else if (cap_valid) begin
            m_post--;
            if (m_post == 0) begin
               m_state = 3;
               m_rdq = m_q;
            end
         end
      end else if (m_state == 3) begin
         if (rd_req && m_rdq.size() > 0) begin
            m_rd_entry = m_rdq.pop_front();
            m_rd_valid = 1;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string nm, input entry_t act, input entry_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("state", entry_t'(dut_state), entry_t'(m_state));
      chk("count", entry_t'(dut_count), entry_t'(m_q.size()));
      chk("triggered", entry_t'(dut_trig), entry_t'(m_trig));
      chk("rd_valid", entry_t'(dut_valid), entry_t'(m_rd_valid));
      chk("rd_entry", dut_entry, m_rd_entry);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rstn) model_update();
      else model_reset();
      @(negedge clk);
      compare();
   endtask

   function automatic entry_t pc_of(input entry_t e);
      return entry_t'(e[ENTRY_W-1 -: PW]);
   endfunction

   task automatic do_arm();
      arm = 1'b1;
      cyc();
      arm = 1'b0;
   endtask

   task automatic cap(input logic [PW-1:0] pc);
      cap_valid = 1'b1;
      cap_pc    = pc;
      cap_waddr = pc[6:2];
      cap_data  = $urandom;
      cyc();
      cap_valid = 1'b0;
   endtask

   task automatic rd();
      rd_req = 1'b1;
      cyc();
      rd_req = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
      force_trig = 1'b0; post_count = '0; cap_valid = 1'b0;
      cap_pc = '0; cap_waddr = '0; cap_data = '0; rd_req = 1'b0;
      model_reset();
      cyc();
      cyc();
      chk("reset_state", entry_t'(dut_state), entry_t'(0));
      chk("reset_count", entry_t'(dut_count), entry_t'(0));
      rstn = 1'b1;
      // IDLE ignores traffic
      force_trig = 1'b1; cap(32'h40); force_trig = 1'b0;
      chk("idle_ignore", entry_t'(dut_state), entry_t'(0));

      // Basic capture, trigger at 0x08, two post entries
      trig_en = 1'b1; trig_pc = 32'h08; post_count = 2;
      do_arm();
      for (int i = 0; i < 5; i++) cap(PW'(4 * i));
      chk("t1_state", entry_t'(dut_state), entry_t'(3));
      chk("t1_count", entry_t'(dut_count), entry_t'(5));
      chk("t1_model_cnt", entry_t'(m_q.size()), entry_t'(5));
      for (int k = 0; k < 5; k++) begin
         rd();
         chk("t1_rd_pc", pc_of(dut_entry), entry_t'(4 * k));
      end
      rd();
      chk("t1_rd6_valid", entry_t'(dut_valid), entry_t'(0));

      // Wrap: 24 captures into 16 entries
      trig_pc = 32'h50; post_count = 3;
      do_arm();
      for (int i = 0; i < 24; i++) cap(PW'(4 * i));
      chk("wrap_count", entry_t'(dut_count), entry_t'(16));
      for (int k = 0; k < 16; k++) begin
         rd();
         chk("wrap_rd_pc", pc_of(dut_entry), entry_t'(32'h20 + 4 * k));
      end

      // post_count = 0: trigger entry is the last one
      trig_pc = 32'h0C; post_count = 0;
      do_arm();
      for (int i = 0; i < 4; i++) cap(PW'(4 * i));
      chk("p0_state", entry_t'(dut_state), entry_t'(3));
      cap(32'h10); cap(32'h14);
      chk("p0_count", entry_t'(dut_count), entry_t'(4));
      for (int k = 0; k < 4; k++) rd();
      chk("p0_last_pc", pc_of(dut_entry), entry_t'(32'h0C));

      // Forced trigger without capture
      trig_en = 1'b0; post_count = 4;
      do_arm();
      force_trig = 1'b1; cyc(); force_trig = 1'b0;
      chk("ft_post", entry_t'(dut_state), entry_t'(2));
      for (int i = 0; i < 4; i++) cap(PW'(32'h300 + 4 * i));
      chk("ft_done", entry_t'(dut_state), entry_t'(3));
      chk("ft_count", entry_t'(dut_count), entry_t'(4));
      force_trig = 1'b1; cyc(); force_trig = 1'b0;
      chk("ft_again", entry_t'(dut_count), entry_t'(4));

      // Gapped capture with fixed waddr/data
      post_count = 1;
      do_arm();
      cap_waddr = 5'd5; cap_data = 32'hDEADBEEF;
      cap_valid = 1'b1; cap_pc = 32'h100; force_trig = 1'b1; cyc();
      cap_valid = 1'b0; force_trig = 1'b0; cyc();
      cap_valid = 1'b1; cap_pc = 32'h104; cyc();
      cap_valid = 1'b0;
      chk("gap_count", entry_t'(dut_count), entry_t'(2));
      rd();
      chk("gap_entry", dut_entry, {32'h100, 5'd5, 32'hDEADBEEF});

      // Clamp: post_count 31 on 16 entries
      post_count = 31;
      do_arm();
      force_trig = 1'b1; cap(32'h200); force_trig = 1'b0;
      for (int i = 1; i < 21; i++) cap(PW'(32'h200 + 4 * i));
      chk("clamp_count", entry_t'(dut_count), entry_t'(16));
      rd();
      chk("clamp_oldest", pc_of(dut_entry), entry_t'(32'h200));
      for (int k = 1; k < 16; k++) rd();
      chk("clamp_newest", pc_of(dut_entry), entry_t'(32'h23C));

      // Reset mid-POST
      post_count = 5;
      do_arm();
      force_trig = 1'b1; cap(32'h400); force_trig = 1'b0;
      cap(32'h404);
      chk("rst_pre_post", entry_t'(dut_state), entry_t'(2));
      #2 rstn = 1'b0;
      model_reset();
      #1;
      chk("rst_state", entry_t'(dut_state), entry_t'(0));
      chk("rst_count", entry_t'(dut_count), entry_t'(0));
      chk("rst_trig", entry_t'(dut_trig), entry_t'(0));
      chk("rst_valid", entry_t'(dut_valid), entry_t'(0));
      cyc();
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) cap(PW'(32'h500 + 4 * i));
      chk("rst_ignore", entry_t'(dut_count), entry_t'(0));

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         arm        = ($urandom_range(0, 39) == 0);
         if (arm) begin
            trig_pc    = PW'(4 * $urandom_range(0, 15));
            trig_en    = ($urandom_range(0, 4) != 0);
            post_count = CNT_W'($urandom_range(0, 31));
         end
         cap_valid  = ($urandom_range(0, 9) < 6);
         cap_pc     = PW'(4 * $urandom_range(0, 15));
         cap_waddr  = 5'($urandom);
         cap_data   = $urandom;
         force_trig = ($urandom_range(0, 49) == 0);
         rd_req     = $urandom_range(0, 1);
         cyc();
      end
      arm = 1'b0; cap_valid = 1'b0; force_trig = 1'b0; rd_req = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
